// File: rtl/bundle_prefetch_queue.sv
// Fetch stage ahead of VLIW decode: owns the fetch PC, reads instruction memory,
// and buffers {bundle, pc} pairs in a small FIFO drained by decode through a handshake.
module bundle_prefetch_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32
) (
  input  logic                         CLK,
  input  logic                         RESET,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]           imem_data,
  input  logic                         redirect_valid,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         bundle_valid,
  input  logic                         bundle_ready,
  output logic [INSTR_W-1:0]           bundle,
  output logic [ADDR_W-1:0]            bundle_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0]  fetch_pc;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [INSTR_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem   [DEPTH];
  logic               push;
  logic               pop;

  // Handshake: a bundle transfers on a cycle where bundle_valid & bundle_ready are
  // both high at the rising edge and no redirect is present; the head holds otherwise.
  assign imem_addr    = fetch_pc;
  assign bundle_valid = (count != '0);
  assign pop          = bundle_valid & bundle_ready & ~redirect_valid;
  assign push         = ~redirect_valid & ((count < FULL_CNT) | pop);

  // Outputs are forced to zero when empty so stale storage never leaks out.
  assign bundle    = bundle_valid ? data_mem[rd_ptr] : '0;
  assign bundle_pc = bundle_valid ? pc_mem[rd_ptr]   : '0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fetch_pc <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
        wr_ptr   <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: its contents are only visible behind a nonzero count.
  always_ff @(posedge CLK) begin
    if (!RESET && push) begin
      data_mem[wr_ptr] <= imem_data;
      pc_mem[wr_ptr]   <= fetch_pc;
    end
  end

endmodule
